mux_4x_nbit_rr: RTL and testbench
=================================

MUX_4X_NBIT_RR -- requirements
Module: mux_4x_nbit_rr

Interface
REQ-001 SHALL have parameter N, default 8, data width of every channel and of the output.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports a, b, c, d  input  N each  channel data for sel 0, 1, 2 and 3.
REQ-005 SHALL have port in_valid  input  4  bit i means channel i holds data; bit 0 is a, bit 3 is d.
REQ-006 SHALL have port in_ready  output  4  bit i means channel i data is consumed this cycle.
REQ-007 SHALL have port y  output  N  registered output data.
REQ-008 SHALL have port sel  output  2  registered index of the channel that supplied y.
REQ-009 SHALL have port out_valid  output  1  y and sel hold a beat.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the beat this cycle.

Function
REQ-011 SHALL hold a one-entry output register (y, sel, out_valid); the register can load when out_valid=0 or out_ready=1.
REQ-012 SHALL, when the register can load and in_valid!=0, grant exactly one channel g, load y=channel g data, sel=g and out_valid=1 at the next edge.
REQ-013 SHALL drive in_ready combinationally as one-hot of g only while the grant condition of REQ-012 holds; otherwise in_ready=4'b0000.
REQ-014 SHALL, in one cycle, transfer a channel beat only when in_valid[i]=1 and in_ready[i]=1, and SHALL never set more than one in_ready bit.
REQ-015 SHALL clear out_valid at the next edge when out_valid=1, out_ready=1 and no channel is granted.
REQ-016 SHALL hold y, sel and out_valid stable while out_valid=1 and out_ready=0.
REQ-017 SHALL have a latency of one clock from channel acceptance to out_valid; sustained throughput SHALL be one beat per clock when out_ready=1.
REQ-018 SHALL keep a 2-bit priority pointer p; the search order is p, p+1, p+2, p+3 modulo 4, and g is the first requesting channel in that order.
REQ-019 SHALL set p to g+1 modulo 4 on every grant, so g=3 wraps p to 0; p SHALL be unchanged when there is no grant.
REQ-020 SHALL ignore the data of channels whose in_valid is 0; y SHALL retain its previous value when out_valid falls.

Reset
REQ-021 SHALL, when reset=1 at a clock edge, set y=0, sel=2'b00, out_valid=0 and p=0, overriding any grant or acceptance in that cycle.
REQ-022 SHALL drive in_ready=4'b0000 whenever reset=1, so no channel beat is consumed during reset.
REQ-023 SHALL discard a beat held in the output register when reset is applied, and SHALL NOT present it again after reset.

Configuration
REQ-024 SHALL recognise the macro MUX_4X_NBIT_RR_EN.
REQ-025 SHALL, with MUX_4X_NBIT_RR_EN defined, arbitrate round-robin per REQ-018 and REQ-019.
REQ-026 SHALL, without MUX_4X_NBIT_RR_EN, use fixed priority a>b>c>d (search order always 0,1,2,3) and remove the pointer p; all other requirements still apply.

Verification
REQ-027 SHALL cover single channel: N=8, in_valid=4'b0100, c=8'h5A, out_ready=1 -> in_ready=4'b0100 that cycle; next cycle y=8'h5A, sel=2, out_valid=1.
REQ-028 SHALL cover round-robin fairness (macro defined): in_valid=4'b1111 held, out_ready=1, from reset -> sel sequence 0,1,2,3,0 over five consecutive beats.
REQ-029 SHALL cover fixed priority (macro undefined): in_valid=4'b1111 held for 4 cycles -> every beat has sel=0 and in_ready=4'b0001.
REQ-030 SHALL cover backpressure: a beat is loaded and out_ready=0 for 3 cycles -> y and sel are unchanged and in_ready=0 throughout; out_ready=1 then loads the next grant in the same cycle.
REQ-031 SHALL cover drain: out_valid=1, out_ready=1, in_valid=0 -> out_valid=0 at the next edge and y keeps its last value.
REQ-032 SHALL cover reset mid-operation: reset=1 while out_valid=1 and in_valid=4'b1010 -> in_ready=0 during reset; then out_valid=0, y=0, sel=0; the first grant after reset is channel 1 (b).

Source files
------------

// File: rtl/mux_4x_nbit_rr.sv
// mux_4x_nbit_rr: four-channel, N-bit valid/ready multiplexer with a single
// registered output slot. Each cycle the output register can take a new beat,
// exactly one requesting channel is granted and its data is captured.
// Optional macro MUX_4X_NBIT_RR_EN: when defined, channels are arbitrated
// round-robin from a 2-bit priority pointer. When undefined, fixed priority
// a > b > c > d is used and no pointer exists.
module mux_4x_nbit_rr #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic [N-1:0] d,
    input  logic [3:0]   in_valid,
    output logic [3:0]   in_ready,
    output logic [N-1:0] y,
    output logic [1:0]   sel,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [3:0][N-1:0] chan;
    logic [N-1:0]      y_q, y_d;
    logic [1:0]        sel_q, sel_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        base;
    logic [1:0]        scan_idx;
    logic [1:0]        gnt_idx;
    logic              gnt_found;
    logic              grant_en;

    assign chan = {d, c, b, a};

`ifdef MUX_4X_NBIT_RR_EN
    logic [1:0] p_q, p_d;
    assign base = p_q;
`else
    assign base = 2'd0;
`endif

    // Scan channels starting at base; the first requesting one wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 2'd0;
        scan_idx  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = base + 2'(k);
            if (!gnt_found && in_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    // Grant only when the slot is free or being drained, and never in reset.
    always_comb begin
        grant_en = !reset && (!out_valid_q || out_ready) && gnt_found;
        in_ready = grant_en ? (4'b0001 << gnt_idx) : 4'b0000;
    end

    // Next state of the output slot (and pointer when round-robin).
    always_comb begin
        y_d         = y_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
`ifdef MUX_4X_NBIT_RR_EN
        p_d         = p_q;
`endif
        if (grant_en) begin
            y_d         = chan[gnt_idx];
            sel_d       = gnt_idx;
            out_valid_d = 1'b1;
`ifdef MUX_4X_NBIT_RR_EN
            p_d         = gnt_idx + 2'd1;
`endif
        end else if (out_valid_q && out_ready) begin
            // Beat consumed with nothing to replace it; data is kept.
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any held beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q         <= '0;
            sel_q       <= 2'd0;
            out_valid_q <= 1'b0;
`ifdef MUX_4X_NBIT_RR_EN
            p_q         <= 2'd0;
`endif
        end else begin
            y_q         <= y_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
`ifdef MUX_4X_NBIT_RR_EN
            p_q         <= p_d;
`endif
        end
    end

    assign y         = y_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_4x_nbit_rr.sv
// Testbench for mux_4x_nbit_rr (N=8). Randomized and directed stimulus is
// checked against a transaction-level model of the arbitration rules.
module tb_mux_4x_nbit_rr;

    logic       clk;
    logic       reset;
    logic [7:0] a, b, c, d;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [7:0] y;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_y;
    logic [1:0] m_sel;
    logic       m_ov;
    int         m_p;

    mux_4x_nbit_rr #(.N(8)) dut (
        .clk(clk), .reset(reset),
        .a(a), .b(b), .c(c), .d(d),
        .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .sel(sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] chan_of(int i);
        case (i)
            0: return a;
            1: return b;
            2: return c;
            default: return d;
        endcase
    endfunction

    // Which channel the rules say is consumed right now (one-hot or zero).
    function automatic logic [3:0] mdl_ready();
        if (reset || (m_ov && !out_ready)) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            int idx = (m_p + k) % 4;
            if (in_valid[idx]) return 4'b0001 << idx;
        end
        return 4'b0000;
    endfunction

    // Advance the model with the current inputs, then cross the clock edge.
    task automatic tick();
        logic [3:0] r;
        r = mdl_ready();
        if (reset) begin
            m_y = 8'h00; m_sel = 2'd0; m_ov = 1'b0; m_p = 0;
        end else if (r != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (r[i]) begin
                    m_y   = chan_of(i);
                    m_sel = 2'(i);
                    m_ov  = 1'b1;
`ifdef MUX_4X_NBIT_RR_EN
                    m_p   = (i + 1) % 4;
`endif
                end
            end
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_seq();
        reset = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic randomize_data();
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; randomize_data();
        in_valid = 4'($urandom_range(1, 15)); out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_in_ready got %b exp 0000", in_ready);
        end
        tick();
        checks++;
        if (y !== 8'h00 || sel !== 2'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_state got y=%h sel=%0d ov=%b exp y=00 sel=0 ov=0", y, sel, out_valid);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_channel();
        reset_seq();
        randomize_data();
        c = 8'h5A; in_valid = 4'b0100; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++; $display("FAIL single_in_ready got %b exp 0100", in_ready);
        end
        tick();
        checks++;
        if (y !== 8'h5A || sel !== 2'd2 || out_valid !== 1'b1) begin
            errors++; $display("FAIL single_out got y=%h sel=%0d ov=%b exp y=5a sel=2 ov=1", y, sel, out_valid);
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_arbitration();
        logic [3:0] exp_rdy;
        logic [1:0] exp_sel;
        reset_seq();
        in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            randomize_data();
`ifdef MUX_4X_NBIT_RR_EN
            exp_sel = 2'(k % 4);
`else
            exp_sel = 2'd0;
`endif
            exp_rdy = 4'b0001 << exp_sel;
            #1;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++; $display("FAIL arb_in_ready beat %0d got %b exp %b", k, in_ready, exp_rdy);
            end
            tick();
            checks++;
            if (sel !== exp_sel || y !== m_y || out_valid !== 1'b1) begin
                errors++; $display("FAIL arb_beat %0d got sel=%0d y=%h ov=%b exp sel=%0d y=%h ov=1", k, sel, y, out_valid, exp_sel, m_y);
            end
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        reset_seq();
        randomize_data();
        held = b; in_valid = 4'b0010; out_ready = 1'b1;
        #1;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            randomize_data();
            in_valid = 4'($urandom_range(1, 15));
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_in_ready cyc %0d got %b exp 0000", k, in_ready);
            end
            tick();
            checks++;
            if (y !== held || sel !== 2'd1 || out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold cyc %0d got y=%h sel=%0d ov=%b exp y=%h sel=1 ov=1", k, y, sel, out_valid, held);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== mdl_ready() || in_ready === 4'b0000) begin
            errors++; $display("FAIL bp_release_ready got %b exp %b", in_ready, mdl_ready());
        end
        tick();
        checks++;
        if (y !== m_y || sel !== m_sel || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_release_load got y=%h sel=%0d ov=%b exp y=%h sel=%0d ov=1", y, sel, out_valid, m_y, m_sel);
        end
    endtask

    task automatic test_drain();
        logic [7:0] last;
        last = m_y;
        out_ready = 1'b1; in_valid = 4'b0000; randomize_data();
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL drain_in_ready got %b exp 0000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || y !== last) begin
            errors++; $display("FAIL drain got ov=%b y=%h exp ov=0 y=%h", out_valid, y, last);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || y !== last) begin
            errors++; $display("FAIL drain_idle got ov=%b y=%h exp ov=0 y=%h", out_valid, y, last);
        end
    endtask

    task automatic test_reset_mid();
        reset_seq();
        randomize_data();
        in_valid = 4'b0001; out_ready = 1'b0;
        #1;
        tick();
        reset = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL rmid_in_ready got %b exp 0000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || y !== 8'h00 || sel !== 2'd0) begin
            errors++; $display("FAIL rmid_state got ov=%b y=%h sel=%0d exp ov=0 y=00 sel=0", out_valid, y, sel);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++; $display("FAIL rmid_first_grant got %b exp 0010", in_ready);
        end
        tick();
        checks++;
        if (sel !== 2'd1 || y !== b || out_valid !== 1'b1) begin
            errors++; $display("FAIL rmid_first_beat got sel=%0d y=%h ov=%b exp sel=1 y=%h ov=1", sel, y, out_valid, b);
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            randomize_data();
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            reset     = ($urandom_range(0, 49) == 0);
            #1;
            checks++;
            if (in_ready !== mdl_ready() || $countones(in_ready) > 1) begin
                errors++; $display("FAIL rand_in_ready cyc %0d got %b exp %b", k, in_ready, mdl_ready());
            end
            tick();
            checks++;
            if (y !== m_y || sel !== m_sel || out_valid !== m_ov) begin
                errors++; $display("FAIL rand_out cyc %0d got y=%h sel=%0d ov=%b exp y=%h sel=%0d ov=%b", k, y, sel, out_valid, m_y, m_sel, m_ov);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1;
        a = '0; b = '0; c = '0; d = '0;
        in_valid = 4'b0000; out_ready = 1'b0;
        m_y = 8'h00; m_sel = 2'd0; m_ov = 1'b0; m_p = 0;
        test_reset();
        test_single_channel();
        test_arbitration();
        test_backpressure();
        test_drain();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
